alsu_stim_gen: RTL and testbench

Synthesizable stimulus generator that drives the full ALSU input interface: operands, opcode, control flags and the ALSU reset. It sits on the driving side of the ALSU, upstream of the DUT/reference pair, and produces a reset–random–reset vector sequence. A 32-bit LFSR generates the vectors, and a `vec_valid` strobe tells the downstream comparator on which cycles outputs must be checked.

---
 rtl/alsu_stim_gen_if.sv | 26 ++
 rtl/alsu_stim_gen.sv | 184 ++++++++++++++++++
 tb/tb_alsu_stim_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alsu_stim_gen_if.sv
// Stimulus bus between the ALSU stimulus generator and the ALSU DUT/reference pair.
// The generator drives every signal through the master modport.
interface alsu_stim_gen_if;
    logic signed [2:0] A;
    logic signed [2:0] B;
    logic              cin;
    logic              serial_in;
    logic              direction;
    logic              red_op_A;
    logic              red_op_B;
    logic              bypass_A;
    logic              bypass_B;
    logic        [2:0] opcode;
    logic              alsu_rst;
    logic              vec_valid;

    modport master (
        output A, B, cin, serial_in, direction, red_op_A, red_op_B,
               bypass_A, bypass_B, opcode, alsu_rst, vec_valid
    );

    modport slave (
        input  A, B, cin, serial_in, direction, red_op_A, red_op_B,
               bypass_A, bypass_B, opcode, alsu_rst, vec_valid
    );
endinterface

// File: rtl/alsu_stim_gen.sv
// LFSR-driven ALSU stimulus generator: reset, NUM_VECTORS random vectors, reset, done.
// Every output comes straight from a register.
module alsu_stim_gen #(
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter int unsigned NUM_VECTORS = 90000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   stall_i,
    alsu_stim_gen_if.master        stim_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [31:0]            vec_count_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_RUN  = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [31:0] SEED_C  = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] LAST_C  = 32'(NUM_VECTORS);
    // Packed stimulus {alsu_rst, bypass_B, bypass_A, red_op_B, red_op_A, opcode,
    // direction, serial_in, cin, B, A}; QUIET_C holds the ALSU in reset.
    localparam logic [16:0] QUIET_C = 17'h1_0000;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    function automatic logic [16:0] map_fields(input logic [31:0] l);
        logic [2:0] op;
        if ((l[11:10] == 2'b11) && (l[15:12] != 4'h0)) begin
            op = l[11:9] - 3'd4;
        end else begin
            op = l[11:9];
        end
        return {(l[31:28] == 4'h0), (l[27:25] == 3'h0), (l[24:22] == 3'h0),
                (l[21:19] == 3'h0), (l[18:16] == 3'h0), op,
                l[8], l[7], l[6], l[5:3], l[2:0]};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] count_q, count_d;
    logic [16:0] stim_q, stim_d;
    logic        vec_valid_q, vec_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        stall_act_s;

    assign stall_act_s = stall_i && (state_q != S_IDLE);

    // State, LFSR and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_C;
            count_q     <= 32'd0;
            stim_q      <= QUIET_C;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            count_q     <= count_d;
            stim_q      <= stim_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state, LFSR advance and vector count
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        if (stall_act_s) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    lfsr_d = SEED_C;
                    if (start_i) begin
                        state_d = S_PRE;
                        count_d = 32'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRE: begin
                    state_d = S_RUN;
                    lfsr_d  = lfsr_step(lfsr_q);
                    count_d = count_q + 32'd1;
                end
                S_RUN: begin
                    // count_q never exceeds LAST_C, so the count saturates there
                    if (count_q >= LAST_C) begin
                        state_d = S_POST;
                    end else begin
                        lfsr_d  = lfsr_step(lfsr_q);
                        count_d = count_q + 32'd1;
                    end
                end
                S_POST: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    lfsr_d  = SEED_C;
                end
                default: begin
                    state_d = S_IDLE;
                    lfsr_d  = SEED_C;
                    count_d = 32'd0;
                end
            endcase
        end
    end

    // Output register inputs, decoded from the state being entered
    always_comb begin
        stim_d      = stim_q;
        vec_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        if (stall_act_s) begin
            vec_valid_d = 1'b0;
        end else begin
            case (state_d)
                S_IDLE: begin
                    stim_d = QUIET_C;
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end
                S_PRE, S_POST: begin
                    stim_d      = QUIET_C;
                    vec_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
                S_RUN: begin
                    stim_d      = map_fields(lfsr_d);
                    vec_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
                S_DONE: begin
                    stim_d = QUIET_C;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    stim_d = QUIET_C;
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end
            endcase
        end
    end

    assign stim_o.A         = $signed(stim_q[2:0]);
    assign stim_o.B         = $signed(stim_q[5:3]);
    assign stim_o.cin       = stim_q[6];
    assign stim_o.serial_in = stim_q[7];
    assign stim_o.direction = stim_q[8];
    assign stim_o.opcode    = stim_q[11:9];
    assign stim_o.red_op_A  = stim_q[12];
    assign stim_o.red_op_B  = stim_q[13];
    assign stim_o.bypass_A  = stim_q[14];
    assign stim_o.bypass_B  = stim_q[15];
    assign stim_o.alsu_rst  = stim_q[16];
    assign stim_o.vec_valid = vec_valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign vec_count_o      = count_q;

endmodule

// File: tb/tb_alsu_stim_gen.sv
// Bench for alsu_stim_gen: cycle table on a 5-vector instance, hand-written restart
// sequence, and a scoreboarded long run (SEED=0) against an independent model.
module tb_alsu_stim_gen;

    localparam int unsigned N_SHORT = 5;
    localparam int unsigned N_LONG  = 3000;
    localparam logic [16:0] Q       = 17'h1_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, stall = 1'b0;
    logic        start_l = 1'b0, stall_l = 1'b0;
    logic        busy, done, busy_l, done_l;
    logic [31:0] cnt, cnt_l;

    alsu_stim_gen_if sif ();
    alsu_stim_gen_if lif ();

    alsu_stim_gen #(.SEED(32'h0000_0001), .NUM_VECTORS(N_SHORT)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .stim_o(sif), .busy_o(busy), .done_o(done), .vec_count_o(cnt)
    );

    alsu_stim_gen #(.SEED(32'h0000_0000), .NUM_VECTORS(N_LONG)) u_long (
        .clk_i(clk), .rst_i(rst), .start_i(start_l), .stall_i(stall_l),
        .stim_o(lif), .busy_o(busy_l), .done_o(done_l), .vec_count_o(cnt_l)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Reference model: Galois LFSR and field extraction
    function automatic logic [31:0] m_step(input logic [31:0] l);
        logic [31:0] n;
        n = {1'b0, l[31:1]};
        if (l[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [16:0] m_map(input logic [31:0] l);
        logic [2:0] raw, op;
        raw = l[11:9];
        op  = raw;
        if ((raw == 3'd6 || raw == 3'd7) && l[15:12] != 4'd0) op = raw - 3'd4;
        return {l[31:28] == 4'd0, l[27:25] == 3'd0, l[24:22] == 3'd0,
                l[21:19] == 3'd0, l[18:16] == 3'd0, op,
                l[8], l[7], l[6], l[5:3], l[2:0]};
    endfunction

    function automatic logic [16:0] get_s();
        return {sif.alsu_rst, sif.bypass_B, sif.bypass_A, sif.red_op_B, sif.red_op_A,
                sif.opcode, sif.direction, sif.serial_in, sif.cin, sif.B, sif.A};
    endfunction

    function automatic logic [16:0] get_l();
        return {lif.alsu_rst, lif.bypass_B, lif.bypass_A, lif.red_op_B, lif.red_op_A,
                lif.opcode, lif.direction, lif.serial_in, lif.cin, lif.B, lif.A};
    endfunction

    typedef struct {
        logic        r, s, st;
        logic [16:0] stim;
        logic        vv, bsy, dn;
        logic [31:0] c;
    } row_t;

    row_t tbl[$];

    function automatic void add(input logic r, input logic s, input logic st,
                                input logic [16:0] stim, input logic vv,
                                input logic bsy, input logic dn, input logic [31:0] c);
        row_t x;
        x = '{r, s, st, stim, vv, bsy, dn, c};
        tbl.push_back(x);
    endfunction

    // One full run from start, with an optional stall of 3 cycles after vector 2
    function automatic void add_run(input bit with_stall);
        logic [31:0] l;
        l = 32'h1;
        add(1'b0, 1'b1, 1'b0, Q, 1'b1, 1'b1, 1'b0, 32'd0);
        for (int k = 1; k <= int'(N_SHORT); k++) begin
            l = m_step(l);
            add(1'b0, 1'b0, 1'b0, m_map(l), 1'b1, 1'b1, 1'b0, 32'(k));
            if (with_stall && k == 2) begin
                for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 1'b1, m_map(l), 1'b0, 1'b1, 1'b0, 32'd2);
            end
        end
        add(1'b0, 1'b0, 1'b0, Q, 1'b1, 1'b1, 1'b0, 32'(N_SHORT));
        add(1'b0, 1'b0, 1'b0, Q, 1'b0, 1'b0, 1'b1, 32'(N_SHORT));
        add(1'b0, 1'b0, 1'b0, Q, 1'b0, 1'b0, 1'b0, 32'(N_SHORT));
    endfunction

    task automatic tick(input logic r, input logic s, input logic st);
        rst = r; start = s; stall = st;
        @(negedge clk);
    endtask

    // Long-run scoreboard: expectations queued at start, popped on each vec_valid
    logic [16:0] sbq[$];
    int          n_inv = 0, n_reda = 0, n_rst = 0;

    always @(negedge clk) begin
        if (lif.vec_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("long unexpected vec_valid", 64'(get_l()), 64'h1_FFFF_FFFF);
            end else begin
                chk("long vector", 64'(get_l()), 64'(sbq.pop_front()));
            end
            if (lif.opcode >= 3'd6) n_inv++;
            if (lif.red_op_A) n_reda++;
            if (lif.alsu_rst && busy_l) n_rst++;
        end
    end

    int lo, hi, vv_cnt, row_n;

    initial begin
        // Reset (rst beats a simultaneous start), then stall in IDLE has no effect
        add(1'b1, 1'b0, 1'b0, Q, 1'b0, 1'b0, 1'b0, 32'd0);
        add(1'b1, 1'b1, 1'b0, Q, 1'b0, 1'b0, 1'b0, 32'd0);
        add(1'b1, 1'b0, 1'b0, Q, 1'b0, 1'b0, 1'b0, 32'd0);
        add(1'b0, 1'b0, 1'b1, Q, 1'b0, 1'b0, 1'b0, 32'd0);
        lo = tbl.size();
        add_run(1'b0);
        hi = tbl.size();
        add_run(1'b1);

        vv_cnt = 0;
        row_n  = tbl.size();
        for (int i = 0; i < row_n; i++) begin
            tick(tbl[i].r, tbl[i].s, tbl[i].st);
            chk($sformatf("row %0d", i),
                64'({get_s(), sif.vec_valid, busy, done, cnt}),
                64'({tbl[i].stim, tbl[i].vv, tbl[i].bsy, tbl[i].dn, tbl[i].c}));
            if (i >= lo && i < hi && sif.vec_valid === 1'b1) vv_cnt++;
        end
        chk("vec_valid cycles in run", 64'(vv_cnt), 64'd7);

        // Mid-run reset with a start pulse during RUN ignored
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("start in RUN ignored", 64'({get_s(), busy, cnt}), 64'({m_map(m_step(m_step(32'h1))), 1'b1, 32'd2}));
        tick(1'b0, 1'b0, 1'b0);
        chk("vector 3 count", 64'(cnt), 64'd3);
        tick(1'b1, 1'b0, 1'b0);
        chk("mid-run reset", 64'({get_s(), sif.vec_valid, busy, done, cnt}), 64'({Q, 1'b0, 1'b0, 1'b0, 32'd0}));
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("first vector after restart", 64'({get_s(), cnt}), 64'({17'h0_D003, 32'd1}));
        for (int c = 0; c < 20 && done !== 1'b1; c++) tick(1'b0, 1'b0, 1'b0);
        chk("done after restart", 64'({done, cnt}), 64'({1'b1, 32'(N_SHORT)}));

        // Long scoreboarded run on the SEED=0 instance
        begin
            logic [31:0] l;
            l = 32'h1;
            sbq.push_back(Q);
            for (int k = 0; k < int'(N_LONG); k++) begin
                l = m_step(l);
                sbq.push_back(m_map(l));
            end
            sbq.push_back(Q);
        end
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        for (int c = 0; c < int'(N_LONG) + 20 && done_l !== 1'b1; c++) @(negedge clk);
        chk("long done seen", 64'(done_l), 64'd1);
        chk("long count", 64'(cnt_l), 64'(N_LONG));
        chk("long queue drained", 64'(sbq.size()), 64'd0);
        chk("invalid opcode share", 64'(n_inv > 5 && n_inv < 150), 64'd1);
        chk("red_op_A share", 64'(n_reda > 200 && n_reda < 600), 64'd1);
        chk("alsu_rst share", 64'(n_rst > 90 && n_rst < 330), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
